imem_loader: RTL and testbench

//  Write-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake,

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_byte_packer.sv | 55 +++++
 rtl/imem_loader.sv | 215 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: constants and loader state type shared by the instruction memory
// and its write-side loader.
package imem_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 8;
  localparam int BYTE_WIDTH     = 8;
  localparam int MEM_DEPTH      = 1 << ADDR_WIDTH;
  localparam int COUNT_WIDTH    = ADDR_WIDTH + 1;  // 0..MEM_DEPTH words
  localparam int BYTES_PER_WORD = INST_WIDTH / BYTE_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles BYTES stream beats into one little-endian word.
// The first accepted beat lands in the lowest byte lane. word/word_valid are
// presented combinationally in the cycle the final beat is accepted, so the
// owner can register the complete word on that same edge. BYTES must be >= 2.
module imem_byte_packer #(
  parameter int BYTE_W = 8,
  parameter int BYTES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    byte_valid,
  input  logic [BYTE_W-1:0]       byte_in,
  output logic [BYTE_W*BYTES-1:0] word,
  output logic                    word_valid
);

  localparam int WORD_W = BYTE_W * BYTES;
  localparam int CNT_W  = $clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // New beats enter at the top and older ones shift down, so after BYTES
  // beats the first one sits in the lowest lane.
  assign word       = {byte_in, shreg_q[WORD_W-1:BYTE_W]};
  assign word_valid = byte_valid && (cnt_q == LAST_IDX);

  // Next-state: clear drops any partial word and wins over a beat in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every _d; nothing can infer a latch.
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      shreg_d = word;
      cnt_d   = cnt_q + CNT_W'(1);  // wraps to 0 after the last beat
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream to IMEM write-port loader. Packs four accepted
// bytes little-endian into one instruction word, writes it at an incrementing
// (wrapping) word address, and holds the core stalled while busy.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to append a 4-byte
// little-endian checksum (32-bit sum of all written words) to every load.
module imem_loader
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic                   abort,
  input  logic [BYTE_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [INST_WIDTH-1:0]  mem_wdata,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err
);

  loader_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   in_ready_q, in_ready_d;
  logic                   mem_we_q, mem_we_d;
  logic [INST_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [INST_WIDTH-1:0]  sum_q, sum_d;
`endif

  logic                  pack_clear;
  logic                  byte_fire;
  logic [INST_WIDTH-1:0] pack_word;
  logic                  pack_word_valid;

  assign byte_fire = in_valid && in_ready_q;

  imem_byte_packer #(
    .BYTE_W (BYTE_WIDTH),
    .BYTES  (BYTES_PER_WORD)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .byte_valid (byte_fire),
    .byte_in    (in_data),
    .word       (pack_word),
    .word_valid (pack_word_valid)
  );

  // Next-state and next-output logic; every output is registered, so each
  // transition also sets the output values seen in the destination state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    pack_clear  = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here, so start wins when both arrive together
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          pack_clear  = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d       = '0;
`endif
          if (word_count == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            state_d    = ST_CHECK;
            in_ready_d = 1'b1;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d    = ST_COLLECT;
            in_ready_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        // abort beats a completing word: the partial word is dropped unwritten
        if (abort) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          pack_clear = 1'b1;
        end else if (pack_word_valid) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = pack_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d       = sum_q + pack_word;
`endif
        end else begin
          in_ready_d = 1'b1;
        end
      end

      ST_WRITE: begin
        // The write strobe is already on the port; an abort here only redirects afterwards.
        addr_d      = addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - COUNT_WIDTH'(1);
        if (abort) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (remaining_q == COUNT_WIDTH'(1)) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_d    = ST_CHECK;
          in_ready_d = 1'b1;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d    = ST_COLLECT;
          in_ready_d = 1'b1;
        end
      end

`ifdef IMEM_LOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (abort) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          pack_clear = 1'b1;
        end else if (pack_word_valid) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (pack_word != sum_q) err_d = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
`endif

      ST_DONE: begin
        // The load has already ended; a late abort has nothing left to cancel.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign cpu_hold  = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader. Expected
// writes come from a list-of-words model: word i goes to (base+i) mod depth,
// assembled little-endian from stream bytes 4i..4i+3.
module tb_imem_loader;
  import imem_pkg::*;

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int CSUM_BEATS = CSUM_EN ? 4 : 0;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   abort;
  logic [BYTE_WIDTH-1:0]  in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [INST_WIDTH-1:0]  mem_wdata;
  logic                   busy;
  logic                   cpu_hold;
  logic                   done;
  logic                   err;

  int checks   = 0;
  int failures = 0;

  // Observations gathered by run_load.
  logic [ADDR_WIDTH-1:0] got_addr[$];
  logic [INST_WIDTH-1:0] got_data[$];
  int   done_cnt;
  int   done_cyc;
  int   abort_cyc;
  int   viol;
  logic done_err;
  bit   timed_out;

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Stream for a list of words; the checksum (optionally off by one) is appended when enabled.
  task automatic make_stream(input logic [31:0] words[$], input bit bad_sum,
                             output logic [7:0] bytes[$]);
    logic [31:0] sum;
    sum = 32'd0;
    bytes.delete();
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) bytes.push_back(words[i][8*k +: 8]);
      sum = sum + words[i];
    end
    sum = sum + {31'd0, bad_sum};
    if (CSUM_EN) for (int k = 0; k < 4; k++) bytes.push_back(sum[8*k +: 8]);
  endtask

  // Drives one load and records what the DUT did. Each step runs 1 time unit after a rising edge.
  task automatic run_load(input logic [7:0] base, input int count, input logic [7:0] bytes[$],
                          input int stall_pct, input int abort_at, input bit start_with_abort,
                          input int restart_at);
    int idx;
    int cyc;
    bit v, r, aborted, finished;
    idx = 0; cyc = 0; aborted = 0; finished = 0;
    got_addr.delete(); got_data.delete();
    done_cnt = 0; done_cyc = -1; abort_cyc = -1; viol = 0; done_err = 1'b0; timed_out = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = COUNT_WIDTH'(count);
    abort = start_with_abort; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    while (!finished) begin
      if (mem_we) begin
        got_addr.push_back(mem_waddr);
        got_data.push_back(mem_wdata);
      end
      if (in_ready && (mem_we || !busy)) viol++;
      if (cpu_hold !== busy) viol++;
      if (done) begin
        done_cnt++; done_cyc = cyc; done_err = err;
      end else if (done_cnt > 0) begin
        finished = 1;
      end
      if (cyc >= 3000) begin
        timed_out = 1; finished = 1;
      end
      if (!finished) begin
        abort = 1'b0;
        if (abort_at >= 0 && !aborted && idx == abort_at) begin
          abort = 1'b1; aborted = 1; abort_cyc = cyc;
        end
        start = (cyc == restart_at);
        if (start) begin
          base_addr  = ADDR_WIDTH'($urandom);
          word_count = COUNT_WIDTH'($urandom_range(1, 9));
        end
        if (idx < bytes.size() && !(aborted && !abort) &&
            (abort || $urandom_range(99) >= stall_pct)) begin
          in_valid = 1'b1; in_data = bytes[idx];
        end else begin
          in_valid = 1'b0; in_data = BYTE_WIDTH'($urandom);
        end
        v = in_valid; r = in_ready;
        @(posedge clk); #1;
        if (v && r) idx++;
        cyc++;
      end
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    // After completion the loader must stay quiet.
    repeat (3) begin
      if (mem_we || done || busy || in_ready || cpu_hold) viol++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [INST_WIDTH+ADDR_WIDTH+5:0] outs;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    outs = {in_ready, mem_we, busy, cpu_hold, done, err, mem_waddr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = {in_ready, mem_we, busy, cpu_hold, done, err, mem_waddr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL idle_after_reset: got %h expected 0", outs);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes[$];
    int exp_cyc;
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM_EN) begin
      bytes.push_back(8'hA6); bytes.push_back(8'h00);
      bytes.push_back(8'h10); bytes.push_back(8'h00);
    end
    exp_cyc = 5 * 2 + CSUM_BEATS;
    run_load(8'h10, 2, bytes, 0, -1, 1'b0, -1);
    checks++;
    if (got_addr.size() != 2) begin
      failures++; $display("FAIL basic_write_count: got %0d expected 2", got_addr.size());
    end
    checks++;
    if (got_addr[0] !== 8'h10 || got_data[0] !== 32'h00000013) begin
      failures++;
      $display("FAIL basic_word0: got %h@%h expected 00000013@10", got_data[0], got_addr[0]);
    end
    checks++;
    if (got_addr[1] !== 8'h11 || got_data[1] !== 32'h00100093) begin
      failures++;
      $display("FAIL basic_word1: got %h@%h expected 00100093@11", got_data[1], got_addr[1]);
    end
    checks++;
    if (done_cnt != 1 || done_err !== 1'b0 || timed_out) begin
      failures++;
      $display("FAIL basic_done: pulses %0d err %b timeout %0d expected 1 pulse err 0",
               done_cnt, done_err, timed_out);
    end
    checks++;
    if (done_cyc != exp_cyc) begin
      failures++; $display("FAIL basic_latency: done at cycle %0d expected %0d", done_cyc, exp_cyc);
    end
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL basic_protocol: %0d handshake/hold violations expected 0", viol);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    words = '{$urandom, $urandom};
    make_stream(words, 1'b0, bytes);
    run_load(8'hFF, 2, bytes, 20, -1, 1'b0, -1);
    checks++;
    if (got_addr.size() != 2 || got_addr[0] !== 8'hFF || got_addr[1] !== 8'h00) begin
      failures++;
      $display("FAIL wrap_addr: got %0d writes first %h second %h expected ff then 00",
               got_addr.size(), got_addr[0], got_addr[1]);
    end
    checks++;
    if (got_data[0] !== words[0] || got_data[1] !== words[1]) begin
      failures++;
      $display("FAIL wrap_data: got %h %h expected %h %h", got_data[0], got_data[1],
               words[0], words[1]);
    end
    checks++;
    if (done_cnt != 1 || done_err !== 1'b0 || viol != 0) begin
      failures++;
      $display("FAIL wrap_done: pulses %0d err %b viol %0d expected 1 0 0", done_cnt, done_err, viol);
    end
  endtask

  task automatic test_random_stream();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] words[$];
      logic [7:0]  bytes[$];
      logic [7:0]  base;
      int count, stall, restart, bad;
      bit bad_sum;
      base    = 8'($urandom);
      count   = $urandom_range(1, 6);
      stall   = $urandom_range(10, 70);
      restart = ($urandom_range(1) == 1) ? $urandom_range(1, 4) : -1;
      bad_sum = 1'($urandom);
      words.delete();
      for (int i = 0; i < count; i++) words.push_back($urandom);
      make_stream(words, bad_sum, bytes);
      run_load(base, count, bytes, stall, -1, 1'($urandom), restart);
      bad = 0;
      for (int i = 0; i < count; i++) begin
        if (i >= got_addr.size() || got_addr[i] !== ADDR_WIDTH'((base + i) % MEM_DEPTH) ||
            got_data[i] !== words[i]) bad++;
      end
      checks++;
      if (got_addr.size() != count || bad != 0) begin
        failures++;
        $display("FAIL random_writes[%0d]: got %0d writes %0d wrong expected %0d writes 0 wrong",
                 it, got_addr.size(), bad, count);
      end
      checks++;
      if (done_cnt != 1 || timed_out || done_err !== (bad_sum & CSUM_EN)) begin
        failures++;
        $display("FAIL random_done[%0d]: pulses %0d err %b timeout %0d expected 1 pulse err %b",
                 it, done_cnt, done_err, timed_out, bad_sum & CSUM_EN);
      end
      checks++;
      if (viol != 0) begin
        failures++; $display("FAIL random_protocol[%0d]: %0d violations expected 0", it, viol);
      end
    end
  endtask

  task automatic test_abort();
    int points[$];
    points = '{0, 3, 4, 6, 9, 12};
    foreach (points[p]) begin
      logic [31:0] words[$];
      logic [7:0]  bytes[$];
      logic [7:0]  base;
      int exp_n, bad;
      base  = 8'($urandom);
      words = '{$urandom, $urandom, $urandom};
      make_stream(words, 1'b0, bytes);
      exp_n = points[p] / 4;
      run_load(base, 3, bytes, 0, points[p], 1'b0, -1);
      bad = 0;
      for (int i = 0; i < exp_n; i++) begin
        if (i >= got_addr.size() || got_addr[i] !== ADDR_WIDTH'((base + i) % MEM_DEPTH) ||
            got_data[i] !== words[i]) bad++;
      end
      checks++;
      if (got_addr.size() != exp_n || bad != 0) begin
        failures++;
        $display("FAIL abort_writes[%0d]: got %0d writes %0d wrong expected %0d",
                 points[p], got_addr.size(), bad, exp_n);
      end
      checks++;
      if (done_cnt != 1 || done_err !== 1'b1 || done_cyc != abort_cyc + 1) begin
        failures++;
        $display("FAIL abort_done[%0d]: pulses %0d err %b done cycle %0d expected 1 pulse err 1 cycle %0d",
                 points[p], done_cnt, done_err, done_cyc, abort_cyc + 1);
      end
      checks++;
      if (err !== 1'b1) begin
        failures++; $display("FAIL abort_sticky[%0d]: err %b in idle expected 1", points[p], err);
      end
    end
    // The next accepted start must clear the sticky error.
    begin
      logic [31:0] words[$];
      logic [7:0]  bytes[$];
      words = '{$urandom};
      make_stream(words, 1'b0, bytes);
      run_load(8'h40, 1, bytes, 0, -1, 1'b0, -1);
      checks++;
      if (done_err !== 1'b0 || err !== 1'b0 || got_addr.size() != 1 || got_data[0] !== words[0]) begin
        failures++;
        $display("FAIL abort_recover: err %b/%b writes %0d data %h expected 0/0 1 %h",
                 done_err, err, got_addr.size(), got_data[0], words[0]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [INST_WIDTH+ADDR_WIDTH+5:0] outs;
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    int we_seen;
    we_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h20; word_count = COUNT_WIDTH'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = BYTE_WIDTH'($urandom);
      @(posedge clk); #1;
      if (mem_we) we_seen++;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    outs = {in_ready, mem_we, busy, cpu_hold, done, err, mem_waddr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL midreset_outputs: got %h expected 0", outs);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_we || busy) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      failures++; $display("FAIL midreset_no_write: %0d write/busy cycles expected 0", we_seen);
    end
    // The three pre-reset bytes must not leak into the next word.
    words = '{$urandom};
    make_stream(words, 1'b0, bytes);
    run_load(8'h30, 1, bytes, 0, -1, 1'b0, -1);
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 8'h30 || got_data[0] !== words[0]) begin
      failures++;
      $display("FAIL midreset_next_load: got %0d writes %h@%h expected 1 %h@30",
               got_addr.size(), got_data[0], got_addr[0], words[0]);
    end
  endtask

  task automatic test_zero_count();
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    words.delete();
    make_stream(words, 1'b0, bytes);
    run_load(8'h55, 0, bytes, 0, -1, 1'b0, -1);
    checks++;
    if (got_addr.size() != 0 || done_cnt != 1 || done_err !== 1'b0 || done_cyc != CSUM_BEATS) begin
      failures++;
      $display("FAIL zero_count: writes %0d pulses %0d err %b done cycle %0d expected 0 1 0 %0d",
               got_addr.size(), done_cnt, done_err, done_cyc, CSUM_BEATS);
    end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    words = '{32'h1, 32'h2};
    make_stream(words, 1'b0, bytes);
    checks++;
    if (bytes[8] !== 8'h03) begin
      failures++; $display("FAIL csum_stream: checksum byte %h expected 03", bytes[8]);
    end
    run_load(8'h00, 2, bytes, 0, -1, 1'b0, -1);
    checks++;
    if (done_err !== 1'b0 || got_addr.size() != 2) begin
      failures++;
      $display("FAIL csum_good: err %b writes %0d expected 0 2", done_err, got_addr.size());
    end
    make_stream(words, 1'b1, bytes);
    run_load(8'h00, 2, bytes, 0, -1, 1'b0, -1);
    checks++;
    if (done_err !== 1'b1 || got_addr.size() != 2 || done_cnt != 1) begin
      failures++;
      $display("FAIL csum_bad: err %b writes %0d pulses %0d expected 1 2 1",
               done_err, got_addr.size(), done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random_stream();
    test_abort();
    test_reset_mid_load();
    test_zero_count();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
